// File: rtl/upload_if.sv
// Handshake and status bundle between the byte source / program memory side
// and the upload controller.
interface upload_if;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] mem_wdata;
    logic       mem_we;
    logic       ptr_enable;
    logic       ptr_inc;
    logic [9:0] upload_count;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       bracket_err;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_wdata, mem_we, ptr_enable, ptr_inc,
               upload_count, busy, done, overflow, bracket_err
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_wdata, mem_we, ptr_enable, ptr_inc,
               upload_count, busy, done, overflow, bracket_err
    );
endinterface

// File: rtl/upload_controller.sv
// Upload controller: accepts ASCII program bytes, writes each command as a 4-bit
// opcode to program memory, pulses the pointer stage, and closes with a HALT write.
module upload_controller (
    input  logic    clk,
    input  logic    rst_n,
    upload_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_ADV,
        S_HALT_WR,
        S_DONE
    } state_e;

    localparam logic [3:0] OP_OPEN  = 4'd6;
    localparam logic [3:0] OP_CLOSE = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;
    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [7:0] CH_HALT  = 8'h21;

    state_e     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [9:0] count_q, count_d;
    logic [9:0] depth_q, depth_d;
    logic       overflow_q, overflow_d;
    logic       bracket_err_q, bracket_err_d;

    logic       is_cmd;
    logic [3:0] rx_op;

    always_comb begin
        is_cmd = 1'b1;
        rx_op  = 4'd0;
        case (bus.rx_data)
            8'h3E:   rx_op = 4'd0;
            8'h3C:   rx_op = 4'd1;
            8'h2B:   rx_op = 4'd2;
            8'h2D:   rx_op = 4'd3;
            8'h2E:   rx_op = 4'd4;
            8'h2C:   rx_op = 4'd5;
            8'h5B:   rx_op = OP_OPEN;
            8'h5D:   rx_op = OP_CLOSE;
            default: is_cmd = 1'b0;
        endcase
    end

    // NOTE: every signal driven here gets its default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        count_d       = count_q;
        depth_d       = depth_q;
        overflow_d    = overflow_q;
        bracket_err_d = bracket_err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    count_d       = '0;
                    depth_d       = '0;
                    overflow_d    = 1'b0;
                    bracket_err_d = 1'b0;
                    state_d       = S_RECV;
                end
            end
            S_RECV: begin
                if (bus.rx_valid) begin
                    if (is_cmd) begin
                        if (count_q == CNT_MAX) begin
                            // A full program has no room left, so the command is dropped and the upload closes.
                            overflow_d = 1'b1;
                            state_d    = S_HALT_WR;
                        end else begin
                            opcode_d = rx_op;
                            state_d  = S_WRITE;
                            if (rx_op == OP_OPEN) begin
                                if (depth_q == CNT_MAX) bracket_err_d = 1'b1;
                                else                    depth_d = depth_q + 10'd1;
                            end else if (rx_op == OP_CLOSE) begin
                                if (depth_q == '0) bracket_err_d = 1'b1;
                                else               depth_d = depth_q - 10'd1;
                            end
                        end
                    end else if (bus.rx_data == CH_HALT) begin
                        state_d = S_HALT_WR;
                    end
                end
            end
            S_WRITE: state_d = S_ADV;
            S_ADV: begin
                count_d = count_q + 10'd1;
                state_d = S_RECV;
            end
            S_HALT_WR: begin
                if (depth_q != '0) bracket_err_d = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            opcode_q      <= '0;
            count_q       <= '0;
            depth_q       <= '0;
            overflow_q    <= 1'b0;
            bracket_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            count_q       <= count_d;
            depth_q       <= depth_d;
            overflow_q    <= overflow_d;
            bracket_err_q <= bracket_err_d;
        end
    end

    // Strobes decode straight from the state, so WRITE/HALT_WR and ADV can never overlap.
    assign bus.rx_ready     = (state_q == S_RECV);
    assign bus.mem_we       = (state_q == S_WRITE) || (state_q == S_HALT_WR);
    assign bus.mem_wdata    = (state_q == S_WRITE)   ? opcode_q :
                              (state_q == S_HALT_WR) ? OP_HALT  : 4'd0;
    assign bus.ptr_inc      = (state_q == S_ADV);
    assign bus.busy         = (state_q == S_RECV) || (state_q == S_WRITE) ||
                              (state_q == S_ADV)  || (state_q == S_HALT_WR);
    assign bus.ptr_enable   = bus.busy;
    assign bus.done         = (state_q == S_DONE);
    assign bus.upload_count = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.bracket_err  = bracket_err_q;
endmodule

// File: tb/tb_upload_controller.sv
// Self-checking bench for upload_controller: directed vector table, overflow and
// reset sequences, and random byte streams scored against a stream-level model.
module tb_upload_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upload_if u_if();

    upload_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        string stim;
        int    count;
        logic  berr;
        logic  ovf;
        string wr;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] got_wr[$];
    int         got_incs = 0;
    int         both_hi  = 0;
    int         acc_cyc[$];
    logic [3:0] exp_wr[$];
    int         exp_count;
    logic       exp_ovf;
    logic       exp_berr;
    int         exp_used;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.mem_we) got_wr.push_back(u_if.mem_wdata);
            if (u_if.ptr_inc) got_incs++;
            if (u_if.mem_we && u_if.ptr_inc) both_hi++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream-level reference: walks the bytes once and lists the memory writes.
    task automatic model(input bq_t s);
        int    depth;
        bit    halted;
        int    op;
        string cmds;
        cmds = "><+-.,[]";
        depth = 0;
        halted = 0;
        exp_wr.delete();
        exp_count = 0;
        exp_ovf = 0;
        exp_berr = 0;
        exp_used = 0;
        foreach (s[i]) begin
            if (halted) break;
            exp_used++;
            op = -1;
            for (int k = 0; k < 8; k++) if (s[i] == cmds[k]) op = k;
            if (op >= 0) begin
                if (exp_count == 1023) begin
                    exp_ovf = 1;
                    halted = 1;
                end else begin
                    exp_wr.push_back(4'(op));
                    exp_count++;
                    if (op == 6) begin
                        if (depth == 1023) exp_berr = 1; else depth++;
                    end
                    if (op == 7) begin
                        if (depth == 0) exp_berr = 1; else depth--;
                    end
                end
            end else if (s[i] == 8'h21) begin
                halted = 1;
            end
            if (halted) begin
                exp_wr.push_back(4'd8);
                if (depth != 0) exp_berr = 1;
            end
        end
    endtask

    task automatic do_start();
        got_wr.delete();
        got_incs = 0;
        both_hi = 0;
        acc_cyc.delete();
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with rx_valid still held high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accepted;
        accepted = 0;
        for (int g = 0; g < gap; g++) begin
            u_if.rx_valid = 1'b0;
            u_if.rx_data  = 8'($urandom);
            @(negedge clk);
        end
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        for (int t = 0; t < 20 && !accepted; t++) begin
            if (u_if.rx_ready) begin
                accepted = 1;
                acc_cyc.push_back(cyc);
            end
            @(negedge clk);
        end
        check("accept_in_time", 32'(accepted), 32'd1);
    endtask

    task automatic run_stream(input bq_t s, input int gap_max, input string tag);
        int ready_seen;
        int gap;
        model(s);
        do_start();
        check({tag, "_busy_after_start"}, 32'(u_if.busy), 32'd1);
        check({tag, "_ptr_en_after_start"}, 32'(u_if.ptr_enable), 32'd1);
        check({tag, "_flags_cleared"}, {u_if.overflow, u_if.bracket_err, u_if.upload_count}, 32'd0);
        for (int i = 0; i < exp_used; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            send_byte(s[i], gap);
        end
        ready_seen = 0;
        for (int i = exp_used; i < s.size(); i++) begin
            u_if.rx_data  = s[i];
            u_if.rx_valid = 1'b1;
            for (int t = 0; t < 3; t++) begin
                if (u_if.rx_ready) ready_seen++;
                @(negedge clk);
            end
        end
        u_if.rx_valid = 1'b0;
        for (int t = 0; t < 10 && !u_if.done; t++) @(negedge clk);
        check({tag, "_done"}, 32'(u_if.done), 32'd1);
        check({tag, "_busy_at_done"}, {u_if.busy, u_if.ptr_enable}, 32'd0);
        check({tag, "_trailing_ignored"}, 32'(ready_seen), 32'd0);
        check({tag, "_wr_len"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 32'(got_wr[i]), 32'(exp_wr[i]));
        check({tag, "_count"}, 32'(u_if.upload_count), 32'(exp_count));
        check({tag, "_incs"}, 32'(got_incs), 32'(exp_count));
        check({tag, "_overflow"}, 32'(u_if.overflow), 32'(exp_ovf));
        check({tag, "_bracket_err"}, 32'(u_if.bracket_err), 32'(exp_berr));
        check({tag, "_we_inc_overlap"}, 32'(both_hi), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        bq_t  q;
        int   ready_seen;
        string alpha;

        vecs[0] = '{stim: "+>.!",       count: 3, berr: 1'b0, ovf: 1'b0, wr: "2048"};
        vecs[1] = '{stim: "a+\n-!",     count: 2, berr: 1'b0, ovf: 1'b0, wr: "238"};
        vecs[2] = '{stim: "[[]!",       count: 3, berr: 1'b1, ovf: 1'b0, wr: "6678"};
        vecs[3] = '{stim: "]!",         count: 1, berr: 1'b1, ovf: 1'b0, wr: "78"};
        vecs[4] = '{stim: "[]<,!",      count: 4, berr: 1'b0, ovf: 1'b0, wr: "67158"};
        vecs[5] = '{stim: "!",          count: 0, berr: 1'b0, ovf: 1'b0, wr: "8"};

        u_if.start    = 1'b0;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;

        #3;
        check("reset_outputs",
              {u_if.rx_ready, u_if.mem_we, u_if.mem_wdata, u_if.ptr_inc, u_if.ptr_enable,
               u_if.upload_count, u_if.busy, u_if.done, u_if.overflow, u_if.bracket_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_without_start", {u_if.busy, u_if.done}, 32'd0);

        foreach (vecs[v]) begin
            q.delete();
            for (int i = 0; i < vecs[v].stim.len(); i++) q.push_back(vecs[v].stim[i]);
            run_stream(q, 0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_tbl_count", v), 32'(u_if.upload_count), 32'(vecs[v].count));
            check($sformatf("vec%0d_tbl_flags", v), {u_if.bracket_err, u_if.overflow},
                  {vecs[v].berr, vecs[v].ovf});
            check($sformatf("vec%0d_tbl_wr_len", v), 32'(got_wr.size()), 32'(vecs[v].wr.len()));
            for (int i = 0; i < vecs[v].wr.len() && i < got_wr.size(); i++)
                check($sformatf("vec%0d_tbl_wr%0d", v, i), 32'(got_wr[i]),
                      32'(vecs[v].wr[i] - 8'h30));
            if (v == 0) begin
                for (int i = 1; i < 3 && i < acc_cyc.size(); i++)
                    check($sformatf("accept_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
            end
        end

        // Capacity: 1024 commands fill the program; the last is dropped and HALT follows.
        q.delete();
        repeat (1024) q.push_back(8'h2B);
        q.push_back(8'h21);
        run_stream(q, 0, "ovf");
        check("ovf_tbl_count", 32'(u_if.upload_count), 32'd1023);
        check("ovf_tbl_flag", 32'(u_if.overflow), 32'd1);
        check("ovf_tbl_last_wr", 32'(got_wr.size() > 0 ? got_wr[got_wr.size()-1] : 4'hF), 32'd8);

        // Reset mid-upload with rx_valid held high and start held (ignored while busy).
        do_start();
        u_if.start = 1'b1;
        repeat (5) send_byte(8'h2B, 0);
        check("pre_reset_count", 32'(u_if.upload_count), 32'd4);
        check("pre_reset_we", 32'(u_if.mem_we), 32'd1);
        check("held_valid_not_ready", 32'(u_if.rx_ready), 32'd0);
        u_if.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {u_if.rx_ready, u_if.mem_we, u_if.mem_wdata, u_if.ptr_inc, u_if.ptr_enable,
               u_if.upload_count, u_if.busy, u_if.done, u_if.overflow, u_if.bracket_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_wr.delete();
        ready_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (u_if.rx_ready) ready_seen++;
        end
        check("post_reset_no_write", 32'(got_wr.size()), 32'd0);
        check("post_reset_no_ready", 32'(ready_seen), 32'd0);
        u_if.rx_valid = 1'b0;
        q.delete();
        q.push_back(8'h2B);
        q.push_back(8'h21);
        run_stream(q, 0, "recover");

        // Random streams with idle gaps and junk bytes.
        alpha = "><+-.,[]az\n[]][";
        for (int r = 0; r < 10; r++) begin
            int len;
            q.delete();
            len = int'($urandom_range(0, 30));
            for (int i = 0; i < len; i++)
                q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            q.push_back(8'h21);
            run_stream(q, 2, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
